// File: rtl/sync_up_down_counter_pkg.sv
// Shared constants for the synchronous up/down counter: mode encoding and
// the default counter width used by the surrounding design.
package sync_up_down_counter_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH = 3;

endpackage : sync_up_down_counter_pkg

// File: rtl/sync_up_down_counter_jk_ff.sv
// Single JK flip-flop with synchronous active-high reset to 0.
// {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule : jk_ff

// File: rtl/sync_up_down_counter.sv
// Modulo-2^WIDTH synchronous up/down counter built from toggle-mode JK flops.
// m = MODE_UP counts up, m = MODE_DOWN counts down; rst has priority over m.
module sync_up_down_counter
    import sync_up_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] qn;

    // Bit 0 always toggles; bit i toggles once all lower bits are about to
    // carry (all ones, up) or borrow (all zeros, i.e. all qn ones, down).
    assign t[0] = 1'b1;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_toggle
            assign t[i] = (m == MODE_UP) ? (&q[i-1:0]) : (&qn[i-1:0]);
        end

        for (i = 0; i < WIDTH; i++) begin : g_bit
            jk_ff u_ff (
                .clk (clk),
                .rst (rst),
                .j   (t[i]),
                .k   (t[i]),
                .q   (q[i]),
                .qn  (qn[i])
            );
        end
    endgenerate

endmodule : sync_up_down_counter

// File: tb/tb_sync_up_down_counter.sv
// Self-checking bench for sync_up_down_counter (default width) and jk_ff.
module tb_sync_up_down_counter;

    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         m;
    logic [W-1:0] q;

    logic jk_rst, jk_j, jk_k, jk_q, jk_qn;

    int checks;
    int errors;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q;

    sync_up_down_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .m   (m),
        .q   (q)
    );

    jk_ff jk_u (
        .clk (clk),
        .rst (jk_rst),
        .j   (jk_j),
        .k   (jk_k),
        .q   (jk_q),
        .qn  (jk_qn)
    );

    // clock / reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, push the reference result, wait for the
    // edge and settle so the caller can pop and compare.
    task automatic drive(input logic r, input logic mv);
        rst = r;
        m   = mv;
        if (r === 1'b1)
            model_q = '0;
        else if (mv === 1'b1)
            model_q = model_q + 1'b1;
        else
            model_q = model_q - 1'b1;
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 1'bx);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL reset edge %0d: q=%b expected %b", n, q, e);
            end
        end
    endtask

    task automatic test_count_up();
        logic [W-1:0] e;
        for (int n = 0; n < 10; n++) begin
            drive(1'b0, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL count_up edge %0d: q=%b expected %b", n, q, e);
            end
        end
    endtask

    task automatic test_count_down();
        logic [W-1:0] e;
        for (int n = 0; n < 10; n++) begin
            drive(1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL count_down edge %0d: q=%b expected %b", n, q, e);
            end
        end
    endtask

    task automatic test_mode_reversal();
        logic [W-1:0] e;
        // from 000 step down three times to reach 101
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL reversal_setup edge %0d: q=%b expected %b", n, q, e);
            end
        end
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, (n % 2 == 0) ? 1'b1 : 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL reversal edge %0d: q=%b expected %b", n, q, e);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] e;
        logic         r_seq [3] = '{1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 3; n++) begin
            drive(r_seq[n], 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL reset_mid_count step %0d: q=%b expected %b", n, q, e);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        for (int n = 0; n < 40; n++) begin
            drive(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL random step %0d: q=%b expected %b", n, q, e);
            end
        end
    endtask

    task automatic test_jk_ff();
        logic [1:0] jk_seq [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        logic       q_exp  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        jk_rst = 1'b1; jk_j = 1'b1; jk_k = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (jk_q !== 1'b0) begin
            errors++;
            $display("FAIL jk_init_reset: q=%b expected 0", jk_q);
        end
        jk_rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            {jk_j, jk_k} = jk_seq[n];
            @(posedge clk); #1;
            checks++;
            if (jk_q !== q_exp[n] || jk_qn !== ~q_exp[n]) begin
                errors++;
                $display("FAIL jk jk=%b: q=%b qn=%b expected q=%b", jk_seq[n], jk_q, jk_qn, q_exp[n]);
            end
        end
        jk_rst = 1'b1; jk_j = 1'b1; jk_k = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (jk_q !== 1'b0) begin
            errors++;
            $display("FAIL jk_reset: q=%b expected 0", jk_q);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        model_q = '0;
        rst     = 1'b0;
        m       = 1'b0;
        jk_rst  = 1'b0;
        jk_j    = 1'b0;
        jk_k    = 1'b0;
        @(negedge clk);

        test_reset();
        test_count_up();
        test_count_down();
        test_mode_reversal();
        test_reset_mid_count();
        test_random();
        test_jk_ff();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule : tb_sync_up_down_counter
